pipe_stage_skid: RTL
====================

# pipe_stage_skid

Parametrised pipeline-stage register with a valid/ready handshake, an optional two-entry skid buffer, and flush-with-keep-mask semantics. It generalises the fixed-field stage registers between EX/MEM/WB into one block carrying a packed bus of any width. Back-pressure is propagated without a combinational ready path, and a saturating stall counter is provided for performance monitoring. It sits between any two pipeline stages of the core; the stage bundle is packed into `in_data_i`.

## Interface
- `DATA_W`, 32: width of the packed stage bundle.
- `KEEP_MASK`, `{DATA_W{1'b0}}`: bits set to 1 are loaded from `in_data_i` on flush (PC, trap code, trap flag); all other bits take `BUBBLE`.
- `BUBBLE`, `{DATA_W{1'b0}}`: value loaded into non-kept bits on flush.
- `SKID`, 1: 1 selects a two-entry skid buffer with registered `in_ready_o`; 0 selects a single entry with combinational ready.
- `CNT_W`, 16: width of the stall counter.

Ports:
- `clk_i`, input, 1: clock.
- `rst_i`, input, 1: reset, synchronous, active-high; one clock domain.
- `flush_i`, input, 1: kill the stage contents and insert a bubble.
- `in_valid_i`, input, 1: upstream holds valid data.
- `in_ready_o`, output, 1: this block accepts data this cycle.
- `in_data_i`, input, `DATA_W`: upstream bundle.
- `out_valid_o`, output, 1: `out_data_o` is valid.
- `out_ready_i`, input, 1: downstream accepts data.
- `out_data_o`, output, `DATA_W`: main register contents.
- `stall_cnt_o`, output, `CNT_W`: saturating count of cycles with `out_valid_o & !out_ready_i`.
- `stall_clr_i`, input, 1: synchronously zero `stall_cnt_o`.

## Operation
- A transfer occurs on a clock edge when valid and ready are both 1 on that side.
- States: EMPTY (no valid entry), ONE (main entry valid), TWO (main and skid entries valid; only reachable when `SKID`=1).
- EMPTY:
  - with `in_valid_i`: main ← `in_data_i`, go to ONE.
- ONE:
  - in & out transfer: main ← `in_data_i`, stay in ONE.
  - out only: go to EMPTY.
  - in only (downstream stalled, `SKID`=1): skid ← `in_data_i`, go to TWO.
  - neither: hold.
- TWO:
  - with `out_ready_i`: main ← skid, go to ONE.
  - no input is accepted in TWO.
- `in_ready_o`:
  - `SKID`=1: registered; equals 1 in the next state iff that state is not TWO.
  - `SKID`=0: `!out_valid_o | out_ready_i`, combinational.
- Flush has priority over every handshake:
  - state goes to EMPTY and the skid entry is discarded.
  - main ← `(in_data_i & KEEP_MASK) | (BUBBLE & ~KEEP_MASK)`.
  - `out_valid_o`=0 next cycle; `in_ready_o`=1 next cycle.
  - the upstream beat presented in the flush cycle is not counted as accepted.
- Stall counter:
  - increments by 1 each cycle `out_valid_o & !out_ready_i`.
  - saturates at `2^CNT_W-1`.
  - `stall_clr_i` wins over increment.
  - flush does not affect the counter.
- Reset values: state EMPTY, `out_valid_o`=0, `out_data_o`=0, skid=0, `in_ready_o`=1 (`SKID`=1), `stall_cnt_o`=0.
  - reset overrides flush and any transfer in the same cycle.
  - reset mid-transfer drops both entries.

## Timing
- Latency: `in_data_i` accepted at edge N appears on `out_data_o` with `out_valid_o`=1 after edge N; one cycle.
- Throughput: one beat per cycle with continuous `out_ready_i` in both modes.
- `SKID`=1: no combinational path from `out_ready_i` to `in_ready_o`.
- `SKID`=1: after the first stall cycle, `in_ready_o` drops at the next edge; one extra beat is absorbed in skid.
- `out_data_o` is stable while `out_valid_o & !out_ready_i` (no change without transfer).
- Ordering is strictly FIFO; skid data always leaves after main.

## Structure
- Shared package `pipe_pkg`:
  - state encoding constants (`ST_EMPTY`=2'd0, `ST_ONE`=2'd1, `ST_TWO`=2'd2).
  - default `DATA_W`/`CNT_W`.
  - per-stage `KEEP_MASK` constants (EX/MEM, MEM/WB bundle layouts).
- One sub-module: `sat_counter` (parameter `W`; inputs `inc`, `clr`; output `q`), used for the stall counter.

## Test plan
- Reset then stream 0x11..0x18 with `out_ready_i`=1: outputs appear one cycle later, back-to-back, no gaps; `stall_cnt_o`=0.
- `SKID`=1, send 0xA, 0xB while `out_ready_i`=0: `in_ready_o` drops after 0xB is stored, state TWO; release ready → 0xA then 0xB, no loss or duplication.
- `KEEP_MASK`=32'hFFFF0000, `BUBBLE`=0, flush with `in_data_i`=0x1234ABCD: next cycle `out_data_o`=0x12340000, `out_valid_o`=0, `in_ready_o`=1.
- Flush asserted while in TWO together with `in_valid_i`: both entries dropped, the flushed beat is not delivered, state EMPTY.
- `CNT_W`=4, hold stall 20 cycles: `stall_cnt_o` saturates at 15; `stall_clr_i` with stall still active → 0 next cycle, then 1.
- `SKID`=0, randomised valid/ready for 1000 cycles against a scoreboard: in-order, lossless; `in_ready_o` == `!out_valid_o | out_ready_i` every cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the generic pipeline stage register: state encoding,
// default widths and the keep masks of the core's stage bundles.
package pipe_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_e;

  // EX/MEM: pc[31:8], trap_code[7:3], trap_flag[2] survive a flush.
  localparam logic [31:0] EX_MEM_KEEP_MASK = 32'hFFFF_FFFC;
  // MEM/WB: pc[31:16], trap_code[15:9], trap_flag[8] survive a flush.
  localparam logic [31:0] MEM_WB_KEEP_MASK = 32'hFFFF_FF00;

  function automatic logic [DATA_W_DEF-1:0] flush_merge(
    input logic [DATA_W_DEF-1:0] data,
    input logic [DATA_W_DEF-1:0] keep,
    input logic [DATA_W_DEF-1:0] bubble
  );
    return (data & keep) | (bubble & ~keep);
  endfunction

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage register with optional two-entry skid buffer,
// flush-with-keep-mask and a saturating stall counter.
//
// Handshake: a beat moves across a side on a rising edge exactly when that
// side's valid and ready are both 1; valid never waits on ready, and a beat
// presented during flush is never accepted.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                DATA_W    = DATA_W_DEF,
  parameter logic [DATA_W-1:0] KEEP_MASK = {DATA_W{1'b0}},
  parameter logic [DATA_W-1:0] BUBBLE    = {DATA_W{1'b0}},
  parameter bit                SKID      = 1'b1,
  parameter int                CNT_W     = CNT_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  input  logic              stall_clr_i,
  output logic [1:0]        dbg_state_o
);

  pipe_state_e       state_q, state_d;
  logic [DATA_W-1:0] main_q, skid_q;
  logic              in_xfer, out_xfer;
  logic              load_main_in, load_main_skid, load_skid;

  assign out_valid_o = (state_q != ST_EMPTY);
  assign out_data_o  = main_q;
  assign dbg_state_o = state_q;
  assign in_xfer     = in_valid_i & in_ready_o & ~flush_i;
  assign out_xfer    = out_valid_o & out_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (in_xfer) state_d = ST_ONE;
        ST_ONE: begin
          if (in_xfer && !out_xfer && SKID) state_d = ST_TWO;
          else if (!in_xfer && out_xfer)    state_d = ST_EMPTY;
        end
        ST_TWO:   if (out_ready_i) state_d = ST_ONE;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      ST_EMPTY: load_main_in = in_xfer;
      ST_ONE: begin
        load_main_in = in_xfer & out_xfer;
        load_skid    = in_xfer & ~out_xfer & SKID;
      end
      ST_TWO:   load_main_skid = out_ready_i;
      default: ;
    endcase
  end

  // Flush overrides the handshake loads; the skid copy is simply zeroed.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_q <= '0;
      skid_q <= '0;
    end else if (flush_i) begin
      main_q <= (in_data_i & KEEP_MASK) | (BUBBLE & ~KEEP_MASK);
      skid_q <= '0;
    end else begin
      if (load_main_in)        main_q <= in_data_i;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= in_data_i;
    end
  end

  // With a skid entry, ready is a flop: it looks ahead at the next state so
  // out_ready_i never reaches in_ready_o combinationally.
  if (SKID) begin : g_skid_ready
    logic ready_q;
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        ready_q <= 1'b1;
      end else begin
        ready_q <= (state_d != ST_TWO);
      end
    end
    assign in_ready_o = ready_q;
  end else begin : g_comb_ready
    assign in_ready_o = ~out_valid_o | out_ready_i;
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc   (out_valid_o & ~out_ready_i),
    .clr   (stall_clr_i),
    .q     (stall_cnt_o)
  );

endmodule
